// File: rtl/rs485_bypass_ctrl.sv
// RS-485 channel A ownership sequencer: hands the bus from the MCU to the FPGA
// download UART once the MCU is idle, and guards f_de around every UART frame.
module rs485_bypass_ctrl #(
  parameter int IDLE_CYC    = 16,
  parameter int GUARD_CYC   = 8,
  parameter int TIMEOUT_CYC = 65536,
  parameter int CNT_W       = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic byp_req_i,
  output logic byp_grant_o,
  output logic byp_timeout_o,
  input  logic uart_tx_req_i,
  input  logic uart_tx_busy_i,
  output logic uart_tx_ok_o,
  input  logic mcu_de_i,
  input  logic mcu_txd_i,
  output logic change_bypass_o,
  output logic f_re_o,
  output logic f_de_o
);

  localparam int IW = $clog2(IDLE_CYC + 1);

  typedef enum logic [2:0] {
    S_MCU, S_WAIT, S_ABORT, S_RX, S_SETUP, S_TX, S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic             bypass_q, bypass_d;
  logic             grant_q, grant_d;
  logic             timeout_q, timeout_d;
  logic             txok_q, txok_d;
  logic             fre_q, fre_d;
  logic             fde_q, fde_d;
  logic             mcu_idle;

  assign mcu_idle = !mcu_de_i && mcu_txd_i;

  always_comb begin
    state_d = state_q;
    idle_d  = '0;
    case (state_q)
      S_MCU:   if (byp_req_i) state_d = S_WAIT;
      S_WAIT: begin
        idle_d = mcu_idle ? idle_q + IW'(1) : '0;
        if (!byp_req_i)                            state_d = S_MCU;
        else if (idle_d == IW'(IDLE_CYC))          state_d = S_RX;
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) state_d = S_ABORT;
      end
      S_ABORT: if (!byp_req_i) state_d = S_MCU;
      S_RX: begin
        if (!byp_req_i)         state_d = S_MCU;
        else if (uart_tx_req_i) state_d = S_SETUP;
      end
      S_SETUP: if (cnt_q == CNT_W'(GUARD_CYC - 1)) state_d = S_TX;
      // release requests are deliberately ignored until the frame is back in RX
      S_TX:    if (!uart_tx_req_i && !uart_tx_busy_i) state_d = S_HOLD;
      S_HOLD:  if (cnt_q == CNT_W'(GUARD_CYC - 1)) state_d = S_RX;
      default: state_d = S_MCU;
    endcase
    if (state_d != S_WAIT) idle_d = '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs decode the next state so that they line up with state_q after the edge.
  always_comb begin
    bypass_d  = 1'b0;
    grant_d   = 1'b0;
    txok_d    = 1'b0;
    fre_d     = 1'b0;
    fde_d     = 1'b0;
    timeout_d = (state_q == S_WAIT) && (state_d == S_ABORT);
    case (state_d)
      S_RX: begin
        bypass_d = 1'b1;
        grant_d  = 1'b1;
      end
      S_SETUP, S_HOLD: begin
        bypass_d = 1'b1;
        grant_d  = 1'b1;
        fre_d    = 1'b1;
        fde_d    = 1'b1;
      end
      S_TX: begin
        bypass_d = 1'b1;
        grant_d  = 1'b1;
        fre_d    = 1'b1;
        fde_d    = 1'b1;
        txok_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_MCU;
      cnt_q     <= '0;
      idle_q    <= '0;
      bypass_q  <= 1'b0;
      grant_q   <= 1'b0;
      timeout_q <= 1'b0;
      txok_q    <= 1'b0;
      fre_q     <= 1'b0;
      fde_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      bypass_q  <= bypass_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      txok_q    <= txok_d;
      fre_q     <= fre_d;
      fde_q     <= fde_d;
    end
  end

  assign change_bypass_o = bypass_q;
  assign byp_grant_o     = grant_q;
  assign byp_timeout_o   = timeout_q;
  assign uart_tx_ok_o    = txok_q;
  assign f_re_o          = fre_q;
  assign f_de_o          = fde_q;

endmodule

// File: tb/tb_rs485_bypass_ctrl.sv
// Directed bench for rs485_bypass_ctrl; expected output vectors are queued when
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_rs485_bypass_ctrl;

  logic clk = 1'b0;
  logic rst, byp_req, uart_tx_req, uart_tx_busy, mcu_de, mcu_txd;
  logic byp_grant, byp_timeout, uart_tx_ok, change_bypass, f_re, f_de;

  rs485_bypass_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .byp_req_i       (byp_req),
    .byp_grant_o     (byp_grant),
    .byp_timeout_o   (byp_timeout),
    .uart_tx_req_i   (uart_tx_req),
    .uart_tx_busy_i  (uart_tx_busy),
    .uart_tx_ok_o    (uart_tx_ok),
    .mcu_de_i        (mcu_de),
    .mcu_txd_i       (mcu_txd),
    .change_bypass_o (change_bypass),
    .f_re_o          (f_re),
    .f_de_o          (f_de)
  );

  always #5 clk = ~clk;

  // {change_bypass, byp_grant, byp_timeout, uart_tx_ok, f_re, f_de}
  localparam logic [5:0] O_MCU = 6'b000000;
  localparam logic [5:0] O_RX  = 6'b110000;
  localparam logic [5:0] O_GRD = 6'b110011;
  localparam logic [5:0] O_TX  = 6'b110111;
  localparam logic [5:0] O_TO  = 6'b001000;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp();
    exp_t       e;
    logic [5:0] obs;
    obs = {change_bypass, byp_grant, byp_timeout, uart_tx_ok, f_re, f_de};
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL sb_underflow observed=%b expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
    end
  endtask

  // queue the expectation, advance n cycles, compare
  task automatic step(input string tag, input int n, input logic [5:0] v);
    push(tag, v);
    tick(n);
    pop_cmp();
  endtask

  initial begin
    rst = 1'b1; byp_req = 1'b0; uart_tx_req = 1'b0; uart_tx_busy = 1'b0;
    mcu_de = 1'b0; mcu_txd = 1'b1;
    tick(2);
    step("reset", 1, O_MCU);
    rst = 1'b0;
    step("idle_mcu", 3, O_MCU);

    // takeover with a quiet MCU: grant on the 17th cycle
    byp_req = 1'b1;
    step("t1_c16", 16, O_MCU);
    step("t1_grant", 1, O_RX);

    // frame with guards
    uart_tx_req = 1'b1;
    step("t4_setup1", 1, O_GRD);
    step("t4_setup8", 7, O_GRD);
    step("t4_ok", 1, O_TX);
    uart_tx_busy = 1'b1;
    step("t4_busy", 3, O_TX);
    uart_tx_req = 1'b0;
    step("t4_busy_noreq", 2, O_TX);
    uart_tx_busy = 1'b0;
    step("t4_hold1", 1, O_GRD);
    step("t4_hold8", 7, O_GRD);
    step("t4_rx", 1, O_RX);

    // release during TX: frame completes first
    uart_tx_req = 1'b1;
    step("t5_setup", 1, O_GRD);
    step("t5_ok", 8, O_TX);
    uart_tx_busy = 1'b1;
    byp_req = 1'b0;
    step("t5_tx_held", 3, O_TX);
    uart_tx_busy = 1'b0;
    uart_tx_req = 1'b0;
    step("t5_hold1", 1, O_GRD);
    step("t5_hold8", 7, O_GRD);
    step("t5_rx", 1, O_RX);
    step("t5_release", 1, O_MCU);

    // MCU activity restarts the idle count
    byp_req = 1'b1;
    step("t2_idle10", 11, O_MCU);
    mcu_de = 1'b1;
    step("t2_de", 1, O_MCU);
    mcu_de = 1'b0;
    step("t2_c15", 15, O_MCU);
    step("t2_grant", 1, O_RX);

    // reset mid-TX
    uart_tx_req = 1'b1;
    step("t6_tx", 9, O_TX);
    rst = 1'b1;
    step("t6_rst", 1, O_MCU);
    rst = 1'b0; uart_tx_req = 1'b0; byp_req = 1'b0;
    step("t6_after", 2, O_MCU);

    // MCU never idle: abort after the timeout, no re-arm while req stays high
    mcu_de = 1'b1;
    byp_req = 1'b1;
    step("t3_pre", 65536, O_MCU);
    step("t3_pulse", 1, O_TO);
    step("t3_pulse_end", 1, O_MCU);
    mcu_de = 1'b0;
    step("t3_no_rearm", 30, O_MCU);
    byp_req = 1'b0;
    step("t3_drop", 1, O_MCU);
    byp_req = 1'b1;
    step("t3_c16", 16, O_MCU);
    step("t3_regrant", 1, O_RX);
    byp_req = 1'b0;
    step("end_release", 1, O_MCU);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
